// File: rtl/approx_error_monitor.sv
// Approximate-circuit error monitor.
// Consumes (exact, approx) word pairs over a sweep. Tracks the worst-case absolute error,
// the number of beats whose error exceeds ET, and the number of beats accepted. At the end
// of the sweep it reports pass/fail against ET.
module approx_error_monitor #(
    parameter int unsigned OUT_W = 3,
    parameter int unsigned ET    = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] exact_val,
    input  logic [OUT_W-1:0] approx_val,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] max_err,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [CNT_W-1:0] vec_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [31:0]      EtW    = 32'(ET);

    state_e           state_q, state_d;
    logic [OUT_W-1:0] max_err_q, max_err_d;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic             pass_q, pass_d;

    logic             beat;
    logic             clear;
    logic [OUT_W-1:0] err;
    logic             err_viol;
    logic [OUT_W-1:0] max_err_upd;

    // Absolute difference of the two words; it always fits in OUT_W bits.
    always_comb begin
        if (exact_val >= approx_val) begin
            err = exact_val - approx_val;
        end else begin
            err = approx_val - exact_val;
        end
    end

    // Threshold test at 32 bits, so an ET at or above the word range never trips.
    always_comb begin
        err_viol    = (32'(err) > EtW);
        max_err_upd = (err > max_err_q) ? err : max_err_q;
    end

    // Beat acceptance and sweep-start qualification.
    always_comb begin
        beat  = in_valid & in_ready;
        clear = start & (state_q != StRun);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start launches a sweep; the accepted last beat ends it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StRun;
            StRun:  if (beat && in_last) state_d = StDone;
            StDone: if (start) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: ;
            StRun: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    // Statistics next-state: clear on start, fold in each accepted beat, else hold.
    always_comb begin
        max_err_d  = max_err_q;
        viol_cnt_d = viol_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        pass_d     = pass_q;
        if (clear) begin
            max_err_d  = '0;
            viol_cnt_d = '0;
            vec_cnt_d  = '0;
            pass_d     = 1'b0;
        end else if (beat) begin
            max_err_d = max_err_upd;
            if (vec_cnt_q != CntMax) begin
                vec_cnt_d = vec_cnt_q + CntOne;
            end
            if (err_viol && (viol_cnt_q != CntMax)) begin
                viol_cnt_d = viol_cnt_q + CntOne;
            end
            // Verdict is taken from the final worst case on the edge that enters DONE.
            if (in_last) begin
                pass_d = (32'(max_err_upd) <= EtW);
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_err_q  <= '0;
            viol_cnt_q <= '0;
            vec_cnt_q  <= '0;
            pass_q     <= 1'b0;
        end else begin
            max_err_q  <= max_err_d;
            viol_cnt_q <= viol_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            pass_q     <= pass_d;
        end
    end

    // Drive statistic outputs; pass is masked outside DONE.
    always_comb begin
        max_err  = max_err_q;
        viol_cnt = viol_cnt_q;
        vec_cnt  = vec_cnt_q;
        pass     = pass_q & (state_q == StDone);
    end

endmodule
